axi_hprd_burst2lite: RTL and testbench
======================================

// Module: axi_hprd_burst2lite
// PURPOSE
//  AXI read-burst to AXI4-Lite single-beat converter. It sits directly downstream of the
//  2S:1M high-performance mux read port (axim_ar*/axim_r*) and feeds a 64-bit AXI4-Lite slave.
//  Each accepted burst is split into arlen+1 single Lite reads with up to P_MAXOUT in flight.
//  Lite responses are returned in order as AXI R beats carrying the burst's ID and RLAST.
// PARAMETERS
//  P_AXI_IDWIDTH  5  width of arid/rid
//  P_MAXOUT       4  max Lite reads outstanding (issued, not yet returned); 1..15
// PORTS
//  aclk          in   1    clock; all logic on rising edge
//  areset        in   1    asynchronous, active-high reset
//  s_arid        in   ID   burst ID
//  s_araddr      in   32   burst start address
//  s_arlen       in   4    beats-1 (0..15)
//  s_arsize      in   3    bytes/beat = 1<<size; must be <=3
//  s_arburst     in   2    00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR
//  s_arprot      in   3    forwarded unchanged on every Lite AR
//  s_arvalid     in   1    burst AR valid
//  s_arready     out  1    burst AR ready
//  s_rid         out  ID   latched burst ID
//  s_rdata       out  64   = m_rdata
//  s_rresp       out  2    = m_rresp, per beat
//  s_rlast       out  1    high on final beat of burst
//  s_rvalid      out  1    = m_rvalid while in a burst
//  s_rready      in   1    burst R ready
//  m_araddr      out  32   Lite read address
//  m_arprot      out  3    Lite prot
//  m_arvalid     out  1    Lite AR valid (registered)
//  m_arready     in   1    Lite AR ready
//  m_rdata       in   64   Lite read data
//  m_rresp       in   2    Lite response
//  m_rvalid      in   1    Lite R valid
//  m_rready      out  1    Lite R ready
// BEHAVIOUR
//  Reset (async, areset=1): state=IDLE; m_arvalid=0, s_arready=0, s_rvalid=0, m_rready=0.
//   All counters are cleared. A mid-burst reset abandons the burst; no beats are flushed.
//  FSM states: IDLE, BURST.
//   IDLE: s_arready=1 (combinational on state).
//    s_arvalid&s_arready latches id/addr/len/size/burst/prot; iss_cnt=0, ret_cnt=0,
//    outstanding=0; next state BURST.
//   BURST: s_arready=0.
//    m_arvalid asserts from the cycle after AR accept (latency 1) while
//    iss_cnt<=len && outstanding<P_MAXOUT. Once asserted, it holds until handshake (AXI rule).
//    m_ar handshake: iss_cnt++, m_araddr advances to the next beat address.
//    m_rready=s_rready and s_rvalid=m_rvalid (pass-through, zero latency).
//    s_rlast=(ret_cnt==len). R handshake: ret_cnt++.
//    Handshake with s_rlast -> IDLE; next AR can be accepted the following cycle.
//   outstanding = issued - returned. Simultaneous issue and return in one cycle leaves it
//    unchanged. It never exceeds P_MAXOUT and never underflows.
//   In IDLE, m_rready=0 and s_rvalid=0 (a stray Lite R is not consumed).
//  Address arithmetic (bytes = 1<<size, 32-bit, carry out discarded):
//   FIXED: every beat uses the start address.
//   INCR:  next = (addr & ~(bytes-1)) + bytes. The first beat keeps the unaligned start address.
//   WRAP:  mask = (len+1)*bytes-1; next = (addr & ~mask) | ((addr+bytes) & mask).
//    WRAP is valid only for len in {1,3,7,15}; other lengths are undefined.
//   No 4KB-boundary checking (upstream responsibility).
//  s_rresp passes SLVERR/DECERR per beat. An error does not truncate the burst.
// TESTING
//  1. INCR addr=0x1000 len=3 size=3 -> Lite ARs 0x1000,0x1008,0x1010,0x1018; 4 R beats,
//     rlast on beat 4 only, rid=latched ID.
//  2. WRAP addr=0x1018 len=3 size=3 -> Lite ARs 0x1018,0x1000,0x1008,0x1010.
//  3. FIXED addr=0x2004 len=2 size=2 -> three Lite ARs all 0x2004.
//  4. m_rvalid held 0, m_arready=1, len=15, P_MAXOUT=4 -> exactly 4 ARs issue then stall.
//     Each R handshake allows one more AR. Same-cycle AR+R keeps outstanding=4.
//  5. s_rready toggled 1/0 with m_rresp=2 on beat 2 -> m_rready mirrors s_rready;
//     s_rresp=2 on beat 2 only; all len+1 beats delivered.
//  6. areset pulsed with 2 reads outstanding -> next cycle IDLE, s_arready=1, m_arvalid=0;
//     a new burst completes normally.

Source files
------------

// File: rtl/axi_hprd_burst2lite.sv
// ---------------------------------------------------------------------------
// axi_hprd_burst2lite
//   Converts AXI read bursts into a sequence of single-beat AXI4-Lite reads.
//   Each accepted burst is split into arlen+1 Lite reads, with up to P_MAXOUT
//   reads issued but not yet returned. Lite responses come back in order and
//   are passed straight through as burst R beats. Each beat carries the
//   latched burst ID, and RLAST is set on the final beat.
//
// Ports
//   aclk, areset          clock, asynchronous active-high reset
//   s_ar*                 burst read address channel (slave side)
//   s_r*                  burst read data channel (slave side)
//   m_ar*                 Lite read address channel (master side)
//   m_r*                  Lite read data channel (master side)
// ---------------------------------------------------------------------------
module axi_hprd_burst2lite #(
  parameter int P_AXI_IDWIDTH = 5,
  parameter int P_MAXOUT      = 4
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [P_AXI_IDWIDTH-1:0] s_arid,
  input  logic [31:0]              s_araddr,
  input  logic [3:0]               s_arlen,
  input  logic [2:0]               s_arsize,
  input  logic [1:0]               s_arburst,
  input  logic [2:0]               s_arprot,
  input  logic                     s_arvalid,
  output logic                     s_arready,
  output logic [P_AXI_IDWIDTH-1:0] s_rid,
  output logic [63:0]              s_rdata,
  output logic [1:0]               s_rresp,
  output logic                     s_rlast,
  output logic                     s_rvalid,
  input  logic                     s_rready,
  output logic [31:0]              m_araddr,
  output logic [2:0]               m_arprot,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  input  logic [63:0]              m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rvalid,
  output logic                     m_rready
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [3:0] MAXOUT_C = P_MAXOUT[3:0];

  state_t                     state_r, state_s;
  logic [P_AXI_IDWIDTH-1:0]   id_r, id_s;
  logic [31:0]                addr_r, addr_s;
  logic [3:0]                 len_r, len_s;
  logic [2:0]                 size_r, size_s;
  logic [1:0]                 burst_r, burst_s;
  logic [2:0]                 prot_r, prot_s;
  logic [4:0]                 iss_cnt_r, iss_cnt_s;   // reaches len+1 (16) when all issued
  logic [3:0]                 ret_cnt_r, ret_cnt_s;
  logic [3:0]                 out_cnt_r, out_cnt_s;
  logic                       arvalid_r, arvalid_s;
  logic                       ar_hs_s;
  logic                       r_hs_s;
  logic                       in_burst_s;
  logic                       last_s;

  // Address of the beat following addr for the given burst geometry.
  function automatic logic [31:0] next_beat_addr(
    input logic [31:0] addr,
    input logic [2:0]  size,
    input logic [3:0]  len,
    input logic [1:0]  burst
  );
    logic [31:0] bytes;
    logic [31:0] wrap_mask;
    logic [31:0] result;
    bytes     = 32'd1 << size;
    wrap_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      2'b00:   result = addr;
      2'b10:   result = (addr & ~wrap_mask) | ((addr + bytes) & wrap_mask);
      default: result = (addr & ~(bytes - 32'd1)) + bytes;  // INCR and reserved 11
    endcase
    return result;
  endfunction

  assign in_burst_s = (state_r == ST_BURST);
  assign ar_hs_s    = arvalid_r & m_arready;
  assign r_hs_s     = in_burst_s & m_rvalid & s_rready;
  assign last_s     = (ret_cnt_r == len_r);

  // Ready is withheld while reset is asserted even though the state reads IDLE.
  assign s_arready = (state_r == ST_IDLE) & ~areset;
  assign s_rid     = id_r;
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = in_burst_s & last_s;
  assign s_rvalid  = in_burst_s & m_rvalid;
  assign m_rready  = in_burst_s & s_rready;
  assign m_araddr  = addr_r;
  assign m_arprot  = prot_r;
  assign m_arvalid = arvalid_r;

  // Next-state, address sequencing and issue/return bookkeeping.
  always_comb begin
    state_s   = state_r;
    id_s      = id_r;
    addr_s    = addr_r;
    len_s     = len_r;
    size_s    = size_r;
    burst_s   = burst_r;
    prot_s    = prot_r;
    iss_cnt_s = iss_cnt_r;
    ret_cnt_s = ret_cnt_r;
    out_cnt_s = out_cnt_r;
    arvalid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (s_arvalid) begin
          id_s      = s_arid;
          addr_s    = s_araddr;
          len_s     = s_arlen;
          size_s    = s_arsize;
          burst_s   = s_arburst;
          prot_s    = s_arprot;
          iss_cnt_s = 5'd0;
          ret_cnt_s = 4'd0;
          out_cnt_s = 4'd0;
          // At least one beat exists and nothing is outstanding yet.
          arvalid_s = 1'b1;
          state_s   = ST_BURST;
        end else begin
          arvalid_s = 1'b0;
        end
      end
      ST_BURST: begin
        if (ar_hs_s) begin
          addr_s    = next_beat_addr(addr_r, size_r, len_r, burst_r);
          iss_cnt_s = iss_cnt_r + 5'd1;
        end else begin
          addr_s    = addr_r;
        end
        // Simultaneous issue and return cancel; a return with nothing
        // outstanding is not allowed to wrap the counter.
        case ({ar_hs_s, r_hs_s})
          2'b10:   out_cnt_s = out_cnt_r + 4'd1;
          2'b01:   out_cnt_s = (out_cnt_r != 4'd0) ? (out_cnt_r - 4'd1) : out_cnt_r;
          default: out_cnt_s = out_cnt_r;
        endcase
        if (r_hs_s) begin
          ret_cnt_s = ret_cnt_r + 4'd1;
        end else begin
          ret_cnt_s = ret_cnt_r;
        end
        if (r_hs_s && last_s) begin
          state_s   = ST_IDLE;
          arvalid_s = 1'b0;
        end else begin
          // A pending request stays up until accepted.
          arvalid_s = (arvalid_r & ~ar_hs_s) |
                      ((iss_cnt_s <= {1'b0, len_r}) && (out_cnt_s < MAXOUT_C));
        end
      end
      default: begin
        state_s   = ST_IDLE;
        arvalid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r   <= ST_IDLE;
      id_r      <= '0;
      addr_r    <= 32'd0;
      len_r     <= 4'd0;
      size_r    <= 3'd0;
      burst_r   <= 2'd0;
      prot_r    <= 3'd0;
      iss_cnt_r <= 5'd0;
      ret_cnt_r <= 4'd0;
      out_cnt_r <= 4'd0;
      arvalid_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      id_r      <= id_s;
      addr_r    <= addr_s;
      len_r     <= len_s;
      size_r    <= size_s;
      burst_r   <= burst_s;
      prot_r    <= prot_s;
      iss_cnt_r <= iss_cnt_s;
      ret_cnt_r <= ret_cnt_s;
      out_cnt_r <= out_cnt_s;
      arvalid_r <= arvalid_s;
    end
  end

endmodule

// File: tb/tb_axi_hprd_burst2lite.sv
// ---------------------------------------------------------------------------
// tb_axi_hprd_burst2lite
//   Scoreboard bench: expected Lite addresses and expected R beats are queued
//   when a burst is launched and compared as the DUT hands them over. A small
//   in-order Lite slave model answers with data derived from the address.
// ---------------------------------------------------------------------------
module tb_axi_hprd_burst2lite;

  localparam int IDW    = 5;
  localparam int MAXOUT = 4;

  logic           aclk = 1'b0;
  logic           areset;
  logic [IDW-1:0] s_arid;
  logic [31:0]    s_araddr;
  logic [3:0]     s_arlen;
  logic [2:0]     s_arsize;
  logic [1:0]     s_arburst;
  logic [2:0]     s_arprot;
  logic           s_arvalid;
  logic           s_arready;
  logic [IDW-1:0] s_rid;
  logic [63:0]    s_rdata;
  logic [1:0]     s_rresp;
  logic           s_rlast;
  logic           s_rvalid;
  logic           s_rready;
  logic [31:0]    m_araddr;
  logic [2:0]     m_arprot;
  logic           m_arvalid;
  logic           m_arready;
  logic [63:0]    m_rdata;
  logic [1:0]     m_rresp;
  logic           m_rvalid;
  logic           m_rready;

  axi_hprd_burst2lite #(.P_AXI_IDWIDTH(IDW), .P_MAXOUT(MAXOUT)) dut (
    .aclk(aclk), .areset(areset),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 aclk = ~aclk;

  int num_checks = 0;
  int num_fail   = 0;

  logic [31:0] exp_ar_q[$];
  logic [71:0] exp_r_q[$];   // {id, last, resp, data}
  logic [33:0] lite_q[$];    // {resp, addr} of reads the slave model owes

  logic [2:0] cur_prot;
  int         err_beat;
  int         lite_idx;
  bit         rvalid_en;
  bit         rready_toggle;
  bit         in_burst;
  int         ar_cap;

  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  // Expected address of beat i, computed directly from the start address.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [2:0] size,
                                            input logic [3:0] len, input logic [1:0] burst,
                                            input int i);
    logic [31:0] bytes, total, lower, res;
    bytes = 32'd1 << size;
    total = ({28'd0, len} + 32'd1) * bytes;
    case (burst)
      2'b00: res = start;
      2'b10: begin
        lower = start & ~(total - 32'd1);
        res   = lower + ((start - lower + 32'(i) * bytes) % total);
      end
      default: res = (i == 0) ? start : ((start & ~(bytes - 32'd1)) + 32'(i) * bytes);
    endcase
    return res;
  endfunction

  task automatic start_burst(input logic [IDW-1:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [2:0] prot, input int err);
    logic [31:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, size, len, burst, i);
      exp_ar_q.push_back(a);
      exp_r_q.push_back({id, (i == int'(len)), (i == err) ? 2'b10 : 2'b00, data_of(a)});
    end
    cur_prot  = prot;
    err_beat  = err;
    lite_idx  = 0;
    s_arid    = id;
    s_araddr  = addr;
    s_arlen   = len;
    s_arsize  = size;
    s_arburst = burst;
    s_arprot  = prot;
    s_arvalid = 1'b1;
  endtask

  // One clock: observe handshakes at the negedge, then drive after the posedge.
  task automatic tick();
    logic        arh;
    logic [31:0] e;
    logic [71:0] er;
    logic [33:0] f;
    @(negedge aclk);
    arh = s_arvalid & s_arready;
    if (in_burst) check("rready_mirror", 72'(m_rready), 72'(s_rready));
    if (m_arvalid && m_arready) begin
      if (exp_ar_q.size() == 0) begin
        check("ar_unexpected", 72'(1), 72'(0));
      end else begin
        e = exp_ar_q.pop_front();
        check("ar_addr", 72'(m_araddr), 72'(e));
        check("ar_prot", 72'(m_arprot), 72'(cur_prot));
      end
      lite_q.push_back({(lite_idx == err_beat) ? 2'b10 : 2'b00, m_araddr});
      lite_idx++;
    end
    if (s_rvalid && s_rready) begin
      if (exp_r_q.size() == 0) begin
        check("r_unexpected", 72'(1), 72'(0));
      end else begin
        er = exp_r_q.pop_front();
        check("r_beat", {s_rid, s_rlast, s_rresp, s_rdata}, er);
      end
      if (lite_q.size() > 0) f = lite_q.pop_front();
    end
    check("outstanding_le_max", 72'(lite_q.size() <= MAXOUT), 72'(1));
    if (arh) in_burst = 1'b1;
    @(posedge aclk);
    #1;
    if (arh) s_arvalid = 1'b0;
    m_rvalid  = rvalid_en && (lite_q.size() > 0);
    if (lite_q.size() > 0) begin
      f       = lite_q[0];
      m_rdata = data_of(f[31:0]);
      m_rresp = f[33:32];
    end else begin
      m_rdata = 64'd0;
      m_rresp = 2'b00;
    end
    m_arready = (lite_q.size() < ar_cap);
    s_rready  = rready_toggle ? ~s_rready : 1'b1;
  endtask

  task automatic finish_burst(input string tag);
    int n;
    n = 0;
    while ((exp_r_q.size() > 0) && (n < 2000)) begin
      tick();
      n++;
    end
    check({tag, "_r_done"}, 72'(exp_r_q.size()), 72'(0));
    check({tag, "_ar_done"}, 72'(exp_ar_q.size()), 72'(0));
    in_burst      = 1'b0;
    rready_toggle = 1'b0;
    tick();
    check({tag, "_idle_ready"}, 72'(s_arready), 72'(1));
  endtask

  initial begin
    areset = 1'b1;
    s_arid = '0; s_araddr = 32'd0; s_arlen = 4'd0; s_arsize = 3'd0;
    s_arburst = 2'd0; s_arprot = 3'd0; s_arvalid = 1'b0;
    s_rready = 1'b1; m_arready = 1'b1; m_rdata = 64'd0; m_rresp = 2'b00;
    m_rvalid = 1'b1;
    rvalid_en = 1'b1; rready_toggle = 1'b0; in_burst = 1'b0; ar_cap = 16;
    cur_prot = 3'd0; err_beat = -1; lite_idx = 0;

    // Reset state, with a stray Lite R present.
    repeat (2) @(posedge aclk);
    #1;
    check("rst_arready", 72'(s_arready), 72'(0));
    check("rst_arvalid", 72'(m_arvalid), 72'(0));
    check("rst_rvalid", 72'(s_rvalid), 72'(0));
    check("rst_mrready", 72'(m_rready), 72'(0));
    areset = 1'b0;
    #1;
    check("idle_arready", 72'(s_arready), 72'(1));
    check("idle_stray_rvalid", 72'(s_rvalid), 72'(0));
    check("idle_stray_mrready", 72'(m_rready), 72'(0));
    m_rvalid = 1'b0;
    @(posedge aclk);
    #1;

    // 1: INCR aligned.
    start_burst(5'h0A, 32'h0000_1000, 4'd3, 3'd3, 2'b01, 3'd5, -1);
    finish_burst("incr");

    // 2: WRAP from the middle of the window.
    start_burst(5'h13, 32'h0000_1018, 4'd3, 3'd3, 2'b10, 3'd2, -1);
    finish_burst("wrap");

    // 3: FIXED.
    start_burst(5'h01, 32'h0000_2004, 4'd2, 3'd2, 2'b00, 3'd0, -1);
    finish_burst("fixed");

    // 4: outstanding limit with Lite R held off.
    rvalid_en = 1'b0;
    start_burst(5'h1F, 32'h0000_4000, 4'd15, 3'd3, 2'b01, 3'd7, -1);
    repeat (12) tick();
    check("maxout_stall_cnt", 72'(lite_q.size()), 72'(MAXOUT));
    check("maxout_stall_arvalid", 72'(m_arvalid), 72'(0));
    check("maxout_stall_ar_left", 72'(exp_ar_q.size()), 72'(16 - MAXOUT));
    rvalid_en = 1'b1;
    finish_burst("maxout");

    // 5: toggling s_rready, SLVERR on beat 2.
    rready_toggle = 1'b1;
    start_burst(5'h05, 32'h0000_5000, 4'd3, 3'd3, 2'b01, 3'd1, 1);
    finish_burst("rresp");
    err_beat = -1;

    // 6: reset with two reads outstanding, then a fresh burst.
    ar_cap    = 2;
    rvalid_en = 1'b0;
    start_burst(5'h0C, 32'h0000_6000, 4'd7, 3'd3, 2'b01, 3'd3, -1);
    repeat (8) tick();
    check("prereset_outstanding", 72'(lite_q.size()), 72'(2));
    areset = 1'b1;
    #1;
    check("midrst_arvalid", 72'(m_arvalid), 72'(0));
    check("midrst_arready", 72'(s_arready), 72'(0));
    exp_ar_q.delete();
    exp_r_q.delete();
    lite_q.delete();
    in_burst  = 1'b0;
    s_arvalid = 1'b0;
    m_rvalid  = 1'b0;
    ar_cap    = 16;
    rvalid_en = 1'b1;
    m_arready = 1'b1;
    s_rready  = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    check("postrst_arready", 72'(s_arready), 72'(1));
    check("postrst_arvalid", 72'(m_arvalid), 72'(0));
    // Reserved burst type behaves as INCR, unaligned start.
    start_burst(5'h16, 32'h0000_3003, 4'd4, 3'd2, 2'b11, 3'd4, -1);
    finish_burst("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
    $finish;
  end

endmodule
